axi4_st_rx: RTL and testbench

Receiving end of the team's 16-bit AXI4-Stream link. It accepts beats from a stream master on TDATA/TVALID, drives TREADY from its own buffer occupancy, and stores beats in an internal FIFO. A local consumer drains the FIFO through a first-word-fall-through read port. It also flags master-side protocol violations.

---
 rtl/axi4_st_rx_pkg.sv | 17 +
 rtl/axi4_st_rx_if.sv | 20 ++
 rtl/axi4_st_rx_fifo.sv | 55 +++++
 rtl/axi4_st_rx.sv | 96 +++++++++
 tb/tb_axi4_st_rx.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_st_rx_pkg.sv
// Shared definitions for the 16-bit AXI4-Stream receiver: default width,
// protocol-checker state encoding and pointer-width helper.
package axi4_st_pkg;

    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } chk_state_t;

    // One extra MSB beyond the address bits distinguishes full from empty.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axi4_st_rx_if.sv
// AXI4-Stream handshake bundle between stream master and axi4_st_rx.
// Carries tlast only when AXIS_RX_TLAST_EN is defined.
interface axi4_st_rx_if #(
    parameter int unsigned DATA_W = 16
) ();

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
`ifdef AXIS_RX_TLAST_EN
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
`else
    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
`endif

endinterface

// File: rtl/axi4_st_rx_fifo.sv
// Synchronous FWFT FIFO with MSB-extended pointers; push/pop are gated
// internally by full/empty so callers may request freely.
module axis_rx_fifo
    import axi4_st_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      full,
    output logic                      empty,
    output logic [ptr_w(DEPTH)-1:0]   count
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned AW = PW - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is deliberately not reset; stale contents are hidden by empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_comb begin
        rd_data = '0;
        if (!empty) rd_data = mem[rd_ptr[AW-1:0]];
    end

endmodule

// File: rtl/axi4_st_rx.sv
// AXI4-Stream receiver: buffers beats in a FWFT FIFO and flags master-side
// protocol violations. Optional TLAST support under AXIS_RX_TLAST_EN.
module axi4_st_rx
    import axi4_st_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     in_clk,
    input  logic                     in_rst,
    axi4_st_rx_if.slave              s,
    input  logic                     in_rd_en,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_valid,
    output logic [ptr_w(DEPTH)-1:0]  o_count,
`ifdef AXIS_RX_TLAST_EN
    output logic                     o_last,
    output logic [15:0]              o_pkt_cnt,
`endif
    output logic                     o_proto_err
);

`ifdef AXIS_RX_TLAST_EN
    localparam int unsigned FW = DATA_W + 1;
`else
    localparam int unsigned FW = DATA_W;
`endif

    logic [FW-1:0] wr_word;
    logic [FW-1:0] rd_word;
    logic [FW-1:0] cap_word;
    logic          full;
    logic          empty;
    logic          accept;
    logic          violation;
    chk_state_t    state;

`ifdef AXIS_RX_TLAST_EN
    assign wr_word = {s.tlast, s.tdata};
    assign o_last  = rd_word[DATA_W];
`else
    assign wr_word = s.tdata;
`endif
    assign o_data   = rd_word[DATA_W-1:0];
    assign o_valid  = !empty;
    assign s.tready = !full;
    assign accept   = s.tvalid && !full;

    axis_rx_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (in_clk),
        .rst     (in_rst),
        .wr_en   (s.tvalid),
        .wr_data (wr_word),
        .rd_en   (in_rd_en),
        .rd_data (rd_word),
        .full    (full),
        .empty   (empty),
        .count   (o_count)
    );

    // A stalled beat must stay valid and unchanged (tlast included) until taken.
    assign violation = !s.tvalid || (wr_word != cap_word);

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state       <= ST_IDLE;
            cap_word    <= '0;
            o_proto_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s.tvalid && full) begin
                        state    <= ST_PEND;
                        cap_word <= wr_word;
                    end
                end
                ST_PEND: begin
                    if (violation) o_proto_err <= 1'b1;
                    if (accept)    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef AXIS_RX_TLAST_EN
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst)                   o_pkt_cnt <= '0;
        else if (accept && s.tlast)   o_pkt_cnt <= o_pkt_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_axi4_st_rx.sv
// Randomized + directed bench for axi4_st_rx against a queue-based model.
module tb_axi4_st_rx;

    localparam int unsigned DEPTH = 8;

    logic        in_clk = 1'b0;
    logic        in_rst = 1'b1;
    logic        in_rd_en = 1'b0;
    logic [15:0] o_data;
    logic        o_valid;
    logic [3:0]  o_count;
    logic        o_proto_err;
    logic        tl = 1'b0;
`ifdef AXIS_RX_TLAST_EN
    logic        o_last;
    logic [15:0] o_pkt_cnt;
`endif

    axi4_st_rx_if #(.DATA_W(16)) bus ();

`ifdef AXIS_RX_TLAST_EN
    always_comb bus.tlast = tl;
`endif

    axi4_st_rx #(.DATA_W(16), .DEPTH(DEPTH)) dut (
        .in_clk      (in_clk),
        .in_rst      (in_rst),
        .s           (bus),
        .in_rd_en    (in_rd_en),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_count     (o_count),
`ifdef AXIS_RX_TLAST_EN
        .o_last      (o_last),
        .o_pkt_cnt   (o_pkt_cnt),
`endif
        .o_proto_err (o_proto_err)
    );

    always #5 in_clk = ~in_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: stored words {tlast, tdata} in arrival order.
    logic [16:0] q [$];
    bit          m_err;
    bit          m_pend;
    logic [16:0] m_pend_word;
    logic [15:0] m_pkt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        m_err  = 1'b0;
        m_pend = 1'b0;
        m_pend_word = '0;
        m_pkt  = '0;
    endtask

    task automatic check_all();
        logic [16:0] head;
        head = (q.size() > 0) ? q[0] : 17'h0;
        chk("tready", {31'b0, bus.tready}, {31'b0, q.size() < DEPTH});
        chk("valid",  {31'b0, o_valid},    {31'b0, q.size() > 0});
        chk("count",  {28'b0, o_count},    q.size());
        chk("data",   {16'b0, o_data},     {16'b0, head[15:0]});
        chk("err",    {31'b0, o_proto_err}, {31'b0, m_err});
`ifdef AXIS_RX_TLAST_EN
        chk("last",   {31'b0, o_last},     {31'b0, head[16]});
        chk("pkt",    {16'b0, o_pkt_cnt},  {16'b0, m_pkt});
`endif
    endtask

    task automatic step();
        bit acc, pop;
        logic [16:0] word;
        @(posedge in_clk);
        if (!in_rst) begin
            acc  = bus.tvalid && (q.size() < DEPTH);
            pop  = in_rd_en && (q.size() > 0);
            word = {tl, bus.tdata};
            if (m_pend) begin
                if (!bus.tvalid || word != m_pend_word) m_err = 1'b1;
                if (acc) m_pend = 1'b0;
            end else if (bus.tvalid && !acc) begin
                m_pend      = 1'b1;
                m_pend_word = word;
            end
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back(word);
                if (tl) m_pkt = m_pkt + 16'd1;
            end
        end
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        bus.tvalid = 1'b0;
        bus.tdata  = '0;
        tl         = 1'b0;
        in_rd_en   = 1'b0;
    endtask

    task automatic do_reset();
        in_rst = 1'b1;
        model_reset();
        #1;
        check_all();
        idle_inputs();
        step();
        step();
        in_rst = 1'b0;
        step();
    endtask

    task automatic push(input logic [15:0] d, input logic last);
        bus.tvalid = 1'b1;
        bus.tdata  = d;
        tl         = last;
        step();
        bus.tvalid = 1'b0;
        tl         = 1'b0;
    endtask

    task automatic pop1();
        in_rd_en = 1'b1;
        step();
        in_rd_en = 1'b0;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        #1;
        check_all();
        step();
        chk("rst_tready", {31'b0, bus.tready}, 32'd1);
        chk("rst_data",   {16'b0, o_data},     32'd0);
        #2 in_rst = 1'b0;
        step();

        // Single beat then pop
        push(16'hA5A5, 1'b0);
        chk("single_valid", {31'b0, o_valid}, 32'd1);
        chk("single_data",  {16'b0, o_data},  32'hA5A5);
        chk("single_count", {28'b0, o_count}, 32'd1);
        pop1();
        chk("single_empty", {31'b0, o_valid}, 32'd0);
        chk("single_zero",  {16'b0, o_data},  32'd0);
        pop1();  // pop while empty is ignored

        // Fill to full, hold a 9th beat, release one slot
        for (int i = 1; i <= 8; i++) push(i[15:0], 1'b0);
        chk("full_tready", {31'b0, bus.tready}, 32'd0);
        chk("full_count",  {28'b0, o_count},    32'd8);
        bus.tvalid = 1'b1;
        bus.tdata  = 16'h0009;
        step();
        chk("held_count", {28'b0, o_count}, 32'd8);
        in_rd_en = 1'b1;
        step();
        in_rd_en = 1'b0;
        chk("pop_tready", {31'b0, bus.tready}, 32'd1);
        chk("pop_data2",  {16'b0, o_data},     32'd2);
        step();
        bus.tvalid = 1'b0;
        chk("held_taken", {28'b0, o_count}, 32'd8);
        chk("no_err",     {31'b0, o_proto_err}, 32'd0);
        for (int i = 0; i < 8; i++) pop1();

        // Concurrent push/pop at occupancy 4
        for (int i = 0; i < 4; i++) push(16'h0100 + i[15:0], 1'b0);
        for (int i = 4; i < 24; i++) begin
            bus.tvalid = 1'b1;
            bus.tdata  = 16'h0100 + i[15:0];
            in_rd_en   = 1'b1;
            step();
            chk("conc_count", {28'b0, o_count}, 32'd4);
        end
        idle_inputs();
        chk("conc_head", {16'b0, o_data}, 32'h0114);
        for (int i = 0; i < 4; i++) pop1();

        // Protocol violation while full
        for (int i = 0; i < 8; i++) push(16'h0200 + i[15:0], 1'b0);
        bus.tvalid = 1'b1;
        bus.tdata  = 16'h1234;
        step();
        chk("pend_noerr", {31'b0, o_proto_err}, 32'd0);
        bus.tdata  = 16'h1235;
        step();
        chk("viol_err", {31'b0, o_proto_err}, 32'd1);
        idle_inputs();
        for (int i = 0; i < 3; i++) step();
        chk("viol_sticky", {31'b0, o_proto_err}, 32'd1);
        do_reset();
        chk("viol_clear", {31'b0, o_proto_err}, 32'd0);

        // Asynchronous reset at occupancy 5, mid-cycle
        for (int i = 0; i < 5; i++) push(16'h0300 + i[15:0], 1'b0);
        #2 in_rst = 1'b1;
        model_reset();
        #1;
        chk("arst_valid",  {31'b0, o_valid},    32'd0);
        chk("arst_count",  {28'b0, o_count},    32'd0);
        chk("arst_tready", {31'b0, bus.tready}, 32'd1);
        step();
        in_rst = 1'b0;
        step();
        push(16'h0BEE, 1'b0);
        chk("arst_new", {16'b0, o_data}, 32'h0BEE);
        chk("arst_cnt1", {28'b0, o_count}, 32'd1);
        pop1();

`ifdef AXIS_RX_TLAST_EN
        // Packets of length 1, 4, 2
        begin
            bit lasts [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
            do_reset();
            for (int i = 0; i < 7; i++) push(16'h0400 + i[15:0], lasts[i]);
            chk("pkt_cnt3", {16'b0, o_pkt_cnt}, 32'd3);
            for (int i = 0; i < 7; i++) begin
                chk("pkt_last", {31'b0, o_last}, {31'b0, lasts[i]});
                pop1();
            end
        end
`endif

        // Randomized traffic, mostly protocol-compliant
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (m_pend && bus.tvalid) begin
                if ($urandom_range(0, 63) == 0) bus.tdata = bus.tdata ^ 16'h0001;
            end else begin
                bus.tvalid = ($urandom_range(0, 3) != 0);
                bus.tdata  = 16'($urandom);
                tl         = 1'($urandom);
            end
            in_rd_en = ($urandom_range(0, 2) != 0);
            if (c % 150 == 75) in_rd_en = 1'b0;
            step();
            if (c == 300) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
